// File: rtl/blur_kernel_3x3.sv
// blur_kernel_3x3: 3x3 (1-2-1)x(1-2-1)/16 blur over a line-buffered window, with
// border/unknown-frame pass-through. Define BLUR_GLOW_EN for glow mode (max(centre, blur)).
module blur_kernel_3x3 #(
  parameter int WIDTH    = 8,
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 1024
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] pixel_in,
  input  logic [WIDTH-1:0] tap1,
  input  logic [WIDTH-1:0] tap2,
  input  logic             de_in,
  input  logic             hs_in,
  input  logic             vs_in,
  output logic [WIDTH-1:0] pixel_out,
  output logic             de_out,
  output logic             hs_out,
  output logic             vs_out
);

  localparam int HW = WIDTH + 2;
  localparam int SW = WIDTH + 4;
  localparam int CW = $clog2(H_ACTIVE);
  localparam int RW = $clog2(V_ACTIVE);
  localparam logic [CW-1:0] COL_LAST = CW'(H_ACTIVE - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(V_ACTIVE - 1);

  function automatic logic [HW-1:0] f_hsum(input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b,
                                           input logic [WIDTH-1:0] c);
    return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
  endfunction

  function automatic logic [SW-1:0] f_vsum(input logic [HW-1:0] a,
                                           input logic [HW-1:0] b,
                                           input logic [HW-1:0] c);
    return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
  endfunction

  // Round-half-up divide by 16; the 4080 maximum rounds to 255, so no clamp is needed.
  function automatic logic [WIDTH-1:0] f_round(input logic [SW-1:0] s);
    logic [SW-1:0] t;
    t = s + SW'(8);
    return t[SW-1:4];
  endfunction

  function automatic logic [WIDTH-1:0] f_max(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [WIDTH-1:0] w_row [3];
  logic             w_vs_rise;
  logic             w_de_fall;
  logic             w_border_p1;
  logic [WIDTH-1:0] w_blur;
  logic [WIDTH-1:0] w_interior;

  logic [WIDTH-1:0] r_win_p0 [3];
  logic [WIDTH-1:0] r_win_p1 [3];
  logic [WIDTH-1:0] r_win_p2 [3];
  logic [HW-1:0]    r_h_p2   [3];
  logic [WIDTH-1:0] r_centre_p2;
  logic             r_border_p2;
  logic [WIDTH-1:0] r_pix_p3;

  logic [CW-1:0]    r_col;
  logic [RW-1:0]    r_row;
  logic             r_known;
  logic             r_de_prev;
  logic             r_vs_prev;
  logic [CW-1:0]    r_col_p0, r_col_p1;
  logic [RW-1:0]    r_row_p0, r_row_p1;
  logic             r_known_p0, r_known_p1;

  logic             r_de_p0, r_de_p1, r_de_p2, r_de_p3;
  logic             r_hs_p0, r_hs_p1, r_hs_p2, r_hs_p3;
  logic             r_vs_p0, r_vs_p1, r_vs_p2, r_vs_p3;

  assign w_row[0]  = tap2;
  assign w_row[1]  = tap1;
  assign w_row[2]  = pixel_in;
  assign w_vs_rise = vs_in & ~r_vs_prev;
  assign w_de_fall = ~de_in & r_de_prev;

  assign w_border_p1 = ~r_known_p1 || (r_col_p1 == '0) || (r_col_p1 == COL_LAST) ||
                       (r_row_p1 == '0) || (r_row_p1 == ROW_LAST);

  assign w_blur = f_round(f_vsum(r_h_p2[0], r_h_p2[1], r_h_p2[2]));
`ifdef BLUR_GLOW_EN
  assign w_interior = f_max(r_centre_p2, w_blur);
`else
  assign w_interior = w_blur;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < 3; r++) begin
        r_win_p0[r] <= '0;
        r_win_p1[r] <= '0;
        r_win_p2[r] <= '0;
        r_h_p2[r]   <= '0;
      end
      r_centre_p2 <= '0;
      r_border_p2 <= 1'b0;
      r_pix_p3    <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_known     <= 1'b0;
      r_de_prev   <= 1'b0;
      r_vs_prev   <= 1'b0;
      r_col_p0    <= '0;
      r_col_p1    <= '0;
      r_row_p0    <= '0;
      r_row_p1    <= '0;
      r_known_p0  <= 1'b0;
      r_known_p1  <= 1'b0;
      {r_de_p0, r_de_p1, r_de_p2, r_de_p3} <= '0;
      {r_hs_p0, r_hs_p1, r_hs_p2, r_hs_p3} <= '0;
      {r_vs_p0, r_vs_p1, r_vs_p2, r_vs_p3} <= '0;
    end else begin
      // p0/p1: window shift, free-running through blanking to stay line-locked
      for (int r = 0; r < 3; r++) begin
        r_win_p0[r] <= w_row[r];
        r_win_p1[r] <= r_win_p0[r];
        r_win_p2[r] <= r_win_p1[r];
      end

      r_de_prev <= de_in;
      r_vs_prev <= vs_in;
      r_col     <= !de_in ? '0 : (r_col == COL_LAST) ? r_col : r_col + CW'(1);
      if (w_vs_rise) begin
        r_row   <= '0;
        r_known <= 1'b1;
      end else if (w_de_fall && r_row != ROW_LAST) begin
        r_row <= r_row + RW'(1);
      end

      r_col_p0   <= r_col;
      r_row_p0   <= r_row;
      r_known_p0 <= r_known;
      r_col_p1   <= r_col_p0;
      r_row_p1   <= r_row_p0;
      r_known_p1 <= r_known_p0;

      // p2: horizontal 1-2-1 per row, centre and border decision captured
      for (int r = 0; r < 3; r++) begin
        r_h_p2[r] <= f_hsum(r_win_p0[r], r_win_p1[r], r_win_p2[r]);
      end
      r_centre_p2 <= r_win_p1[1];
      r_border_p2 <= w_border_p1;

      // p3: vertical 1-2-1, rounding, border/blanking select
      r_pix_p3 <= !r_de_p2 ? '0 : r_border_p2 ? r_centre_p2 : w_interior;

      r_de_p0 <= de_in;
      r_de_p1 <= r_de_p0;
      r_de_p2 <= r_de_p1;
      r_de_p3 <= r_de_p2;
      r_hs_p0 <= hs_in;
      r_hs_p1 <= r_hs_p0;
      r_hs_p2 <= r_hs_p1;
      r_hs_p3 <= r_hs_p2;
      r_vs_p0 <= vs_in;
      r_vs_p1 <= r_vs_p0;
      r_vs_p2 <= r_vs_p1;
      r_vs_p3 <= r_vs_p2;
    end
  end

  assign pixel_out = r_pix_p3;
  assign de_out    = r_de_p3;
  assign hs_out    = r_hs_p3;
  assign vs_out    = r_vs_p3;

endmodule

// File: tb/tb_blur_kernel_3x3.sv
// Bench for blur_kernel_3x3: frame-level image model plus literal spot values on a 16x12 raster.
module tb_blur_kernel_3x3;
  localparam int H     = 16;
  localparam int V     = 12;
  localparam int HB    = 6;
  localparam int LT    = H + HB;
  localparam int DEPTH = 8192;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] pixel_in = '0, tap1 = '0, tap2 = '0;
  logic       de_in = 1'b0, hs_in = 1'b0, vs_in = 1'b0;
  logic [7:0] pixel_out;
  logic       de_out, hs_out, vs_out;

  blur_kernel_3x3 #(.WIDTH(8), .H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clock(clock), .reset(reset), .pixel_in(pixel_in), .tap1(tap1), .tap2(tap2),
    .de_in(de_in), .hs_in(hs_in), .vs_in(vs_in), .pixel_out(pixel_out),
    .de_out(de_out), .hs_out(hs_out), .vs_out(vs_out));

  always #5 clock = ~clock;

  int  n_chk = 0, n_pass = 0, n = 0;
  bit  known = 0, vs_prev = 0;
  logic [7:0] img [0:V+1][0:H+3];
  int  edge_of [0:V+1][0:H+3];
  bit  ent_rst [0:DEPTH-1];
  bit  ent_de  [0:DEPTH-1];
  bit  ent_hs  [0:DEPTH-1];
  bit  ent_vs  [0:DEPTH-1];
  logic [7:0] ent_pix  [0:DEPTH-1];
  logic [7:0] out_hist [0:DEPTH-1];

  function automatic void chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d (edge %0d)", nm, act, exp, n - 1);
  endfunction

  function automatic logic [7:0] rnd();
    return 8'($urandom_range(0, 255));
  endfunction

  // Expected output for centre (y,x) straight from the image and the blur definition.
  function automatic logic [7:0] model_pix(input int y, input int x, input bit kn);
    int s, b;
    if (!kn || x == 0 || x >= H - 1 || y == 0 || y >= V - 1) return img[y][x];
    s = 0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        s += (dy == 0 ? 2 : 1) * (dx == 0 ? 2 : 1) * int'(img[y+dy][x+dx]);
    b = (s + 8) / 16;
`ifdef BLUR_GLOW_EN
    if (int'(img[y][x]) > b) b = int'(img[y][x]);
`endif
    return 8'(b);
  endfunction

  task automatic step(input bit r, input bit de, input bit hs, input bit vs,
                      input logic [7:0] pin, input logic [7:0] t1, input logic [7:0] t2,
                      input logic [7:0] exp);
    reset = r; de_in = de; hs_in = hs; vs_in = vs;
    pixel_in = pin; tap1 = t1; tap2 = t2;
    @(posedge clock);
    #1;
    ent_rst[n] = r; ent_de[n] = de; ent_hs[n] = hs; ent_vs[n] = vs;
    ent_pix[n] = de ? exp : 8'd0;
    if (r) known = 0;
    else if (vs && !vs_prev) known = 1;
    vs_prev = r ? 1'b0 : vs;
    n++;
  endtask

  task automatic fill(input int mode);
    for (int y = 0; y <= V + 1; y++)
      for (int x = 0; x <= H + 3; x++)
        case (mode)
          0: img[y][x] = 8'd100;
          2: img[y][x] = 8'd255;
          4: img[y][x] = rnd();
          default: img[y][x] = 8'd0;
        endcase
    if (mode == 1) img[10][10] = 8'd255;
    if (mode == 3) begin img[5][0] = 8'd200; img[V-1][7] = 8'd200; end
  endtask

  task automatic frame(input int rows, input int long_row, input int rst_y, input int rst_x,
                       input bit vs_end);
    int len;
    bit r;
    for (int bl = 0; bl < 2; bl++)
      for (int c = 0; c < LT; c++)
        step(0, 0, (c == H + 1 || c == H + 2), (bl == 0), rnd(), rnd(), rnd(), 8'd0);
    for (int y = 0; y < rows; y++) begin
      len = (y == long_row) ? H + 3 : H;
      for (int x = 0; x < len; x++) begin
        r = (y == rst_y && x == rst_x);
        edge_of[y][x] = n;
        step(r, 1, 0, 0, img[y+1][x], img[y][x], (y > 0) ? img[y-1][x] : rnd(),
             model_pix(y, x, known));
        if (r) begin
          chk("midreset_pix", int'(pixel_out), 0);
          chk("midreset_de", int'(de_out), 0);
        end
      end
      for (int b = 0; b < HB; b++)
        step(0, 0, (b == 1 || b == 2), (vs_end && y == rows - 1), rnd(), rnd(), rnd(), 8'd0);
    end
  endtask

  task automatic lit(input string nm, input int y, input int x, input int off, input int exp);
    chk(nm, int'(out_hist[edge_of[y][x] + off]), exp);
  endtask

  // Compare: outputs after edge e reflect inputs sampled at edge e-3, unless reset intervened.
  always @(negedge clock) begin
    int e;
    bit z;
    if (n > 0) begin
      e = n - 1;
      out_hist[e] = pixel_out;
      if (e >= 3) begin
        z = ent_rst[e] | ent_rst[e-1] | ent_rst[e-2] | ent_rst[e-3];
        chk("pixel_out", int'(pixel_out), z ? 0 : int'(ent_pix[e-3]));
        chk("de_out", int'(de_out), z ? 0 : int'(ent_de[e-3]));
        chk("hs_out", int'(hs_out), z ? 0 : int'(ent_hs[e-3]));
        chk("vs_out", int'(vs_out), z ? 0 : int'(ent_vs[e-3]));
      end
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 8'hAA, 8'hBB, 8'hCC, 8'd0);
    chk("reset_pix", int'(pixel_out), 0);
    chk("reset_de", int'(de_out), 0);
    chk("reset_hs", int'(hs_out), 0);

    fill(0); frame(V, -1, -1, -1, 0);
    lit("flat_interior", 5, 5, 3, 100);
    lit("flat_corner", 0, 0, 3, 100);

    fill(1); frame(V, -1, -1, -1, 0);
`ifdef BLUR_GLOW_EN
    lit("dot_centre", 10, 10, 3, 255);
`else
    lit("dot_centre", 10, 10, 3, 64);
`endif
    lit("dot_orth", 10, 11, 3, 32);
    lit("dot_orth_up", 9, 10, 3, 32);
    lit("dot_diag", 9, 9, 3, 16);
    lit("dot_far", 10, 12, 3, 0);

    fill(2); frame(V, -1, -1, -1, 0);
    lit("white_interior", 6, 7, 3, 255);

    fill(3); frame(V, -1, -1, -1, 1);
    lit("col0_dot", 5, 0, 3, 200);
    lit("col1_blur", 5, 1, 3, 25);
    lit("col1_diag", 4, 1, 3, 13);
    lit("lastrow_dot", V - 1, 7, 3, 200);
    lit("above_lastrow", V - 2, 7, 3, 25);

    fill(4); frame(V + 1, 3, -1, -1, 0);

    fill(1); frame(V, -1, 5, 7, 0);
    lit("unknown_dot", 10, 10, 3, 255);
    lit("unknown_orth", 10, 11, 3, 0);

    fill(1); frame(V, -1, -1, -1, 0);
`ifdef BLUR_GLOW_EN
    lit("impulse_n3", 10, 10, 3, 255);
`else
    lit("impulse_n3", 10, 10, 3, 64);
`endif
    lit("impulse_n2", 10, 10, 2, 32);
    lit("impulse_n4", 10, 10, 4, 32);

    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 8'd0, 8'd0, 8'd0, 8'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
